// File: rtl/ser_line_sched.sv
// Line scheduler: pops one packed line word from a show-ahead FIFO and streams it
// as BEATS memory beats with ready/valid backpressure, counting lines per frame.
module ser_line_sched #(
    parameter int PAR_WIDTH = 509,
    parameter int SER_WIDTH = 50,
    parameter int BEATS     = 10,
    parameter int LINE_AW   = 9,
    parameter int ADDR_W    = 13,
    parameter int MAX_LINE  = 512
) (
    input  logic                 aclk_i,
    input  logic                 aresetn_i,
    input  logic                 start_i,
    input  logic [LINE_AW:0]     lines_i,
    input  logic                 fifoEmpty_i,
    input  logic [PAR_WIDTH-1:0] fifoDout_i,
    output logic                 fifoRd_o,
    output logic                 ser_valid_o,
    input  logic                 ser_ready_i,
    output logic [SER_WIDTH-1:0] ser_data_o,
    output logic [ADDR_W-1:0]    ser_addr_o,
    output logic                 ser_last_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [LINE_AW:0]     line_cnt_o,
    output logic                 line_err_o
);

    localparam int BODY_W = SER_WIDTH * BEATS;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0]    K_LAST = KW'(BEATS - 1);
    localparam logic [LINE_AW:0] MAX_L  = (LINE_AW + 1)'(MAX_LINE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LINE_AW:0]     lines_q;
    logic [LINE_AW:0]     line_cnt_q;
    logic [LINE_AW:0]     cnt_next;
    logic                 err_q;
    logic [BODY_W-1:0]    word_q;
    logic [KW-1:0]        k_q;
    logic [SER_WIDTH-1:0] data_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 last_q;

    logic [LINE_AW-1:0]   line_idx;
    logic                 line_ok;
    logic [ADDR_W-1:0]    line_base;
    logic                 pop;
    logic                 accept;
    logic                 beat_last;

    function automatic logic [SER_WIDTH-1:0] bit_rev(input logic [SER_WIDTH-1:0] v);
        logic [SER_WIDTH-1:0] r;
        for (int unsigned i = 0; i < SER_WIDTH; i++) begin
            r[i] = v[SER_WIDTH-1-i];
        end
        return r;
    endfunction

    assign line_idx  = fifoDout_i[PAR_WIDTH-1 -: LINE_AW];
    assign line_ok   = {1'b0, line_idx} < MAX_L;
    assign line_base = ADDR_W'(line_idx) * ADDR_W'(BEATS);
    assign pop       = (state_q == S_FETCH) && !fifoEmpty_i;
    assign accept    = (state_q == S_SHIFT) && ser_ready_i;
    assign beat_last = (k_q == K_LAST);
    assign cnt_next  = line_cnt_q + (LINE_AW + 1)'(1);

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifoRd_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (lines_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (!fifoEmpty_i) begin
                    fifoRd_o = 1'b1;
                    if (line_ok) begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (accept && beat_last) begin
                    state_d = (cnt_next == lines_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The captured word is kept as a left-shifting register so the next beat's
    // slice always sits in the top SER_WIDTH bits; no variable part-select needed.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            lines_q    <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
            word_q     <= '0;
            k_q        <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start_i) begin
                lines_q    <= lines_i;
                line_cnt_q <= '0;
                err_q      <= 1'b0;
            end

            if (pop) begin
                if (line_ok) begin
                    data_q <= bit_rev(fifoDout_i[BODY_W-1 -: SER_WIDTH]);
                    word_q <= fifoDout_i[BODY_W-1:0] << SER_WIDTH;
                    addr_q <= line_base;
                    k_q    <= '0;
                    last_q <= (BEATS == 1);
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (accept) begin
                if (beat_last) begin
                    line_cnt_q <= cnt_next;
                end else begin
                    data_q <= bit_rev(word_q[BODY_W-1 -: SER_WIDTH]);
                    word_q <= word_q << SER_WIDTH;
                    addr_q <= addr_q + ADDR_W'(1);
                    k_q    <= k_q + KW'(1);
                    last_q <= ((k_q + KW'(1)) == K_LAST);
                end
            end
        end
    end

    assign ser_valid_o  = (state_q == S_SHIFT);
    assign ser_data_o   = data_q;
    assign ser_addr_o   = addr_q;
    assign ser_last_o   = last_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);
    assign line_cnt_o   = line_cnt_q;
    assign line_err_o   = err_q;

endmodule

// File: tb/tb_ser_line_sched.sv
// Directed self-checking bench for ser_line_sched with a queue-backed show-ahead FIFO.
module tb_ser_line_sched;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         start;
  logic [9:0]   lines;
  logic         fifo_empty;
  logic [508:0] fifo_dout;
  logic         fifo_rd;
  logic         ser_valid;
  logic         ser_ready;
  logic [49:0]  ser_data;
  logic [12:0]  ser_addr;
  logic         ser_last;
  logic         busy;
  logic         frame_done;
  logic [9:0]   line_cnt;
  logic         line_err;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int rd_viol = 0;
  int pops_base;
  logic [508:0] fifo_q[$];

  ser_line_sched #(.MAX_LINE(500)) dut (
    .aclk_i      (aclk),
    .aresetn_i   (aresetn),
    .start_i     (start),
    .lines_i     (lines),
    .fifoEmpty_i (fifo_empty),
    .fifoDout_i  (fifo_dout),
    .fifoRd_o    (fifo_rd),
    .ser_valid_o (ser_valid),
    .ser_ready_i (ser_ready),
    .ser_data_o  (ser_data),
    .ser_addr_o  (ser_addr),
    .ser_last_o  (ser_last),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .line_cnt_o  (line_cnt),
    .line_err_o  (line_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [49:0] slice_val(input int seed, input int j);
    return {8'(seed), 10'(j), 32'hA5C3_0F01 + 32'(j) * 32'h0101_0101};
  endfunction

  function automatic logic [508:0] make_word(input int line, input int seed);
    logic [508:0] w;
    w = '0;
    w[508 -: 9] = 9'(line);
    for (int unsigned j = 0; j < 10; j++) w[50*j +: 50] = slice_val(seed, j);
    return w;
  endfunction

  function automatic logic [49:0] rev50(input logic [49:0] v);
    logic [49:0] r;
    for (int unsigned i = 0; i < 50; i++) r[i] = v[49-i];
    return r;
  endfunction

  task automatic upd_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic step();
    logic rd;
    logic [508:0] tmp;
    rd = fifo_rd;
    if (rd && fifo_empty) rd_viol++;
    @(posedge aclk);
    #2;
    if (rd && fifo_q.size() > 0) begin
      tmp = fifo_q.pop_front();
      pops++;
    end
    upd_fifo();
  endtask

  task automatic run_line(input int line, input int seed, input bit toggle);
    int k;
    int budget;
    bit rdy;
    k = 0;
    budget = 0;
    rdy = 1'b1;
    while (k < 10 && budget < 200) begin
      ser_ready = toggle ? rdy : 1'b1;
      #1;
      if (ser_valid) begin
        checks++;
        if (ser_data !== rev50(slice_val(seed, 9 - k))) begin
          failures++; $error("FAIL beat_data observed=%0h k=%0d", ser_data, k);
        end
        checks++;
        if (ser_addr !== 13'(line * 10 + k)) begin
          failures++; $error("FAIL beat_addr observed=%0h k=%0d", ser_addr, k);
        end
        checks++;
        if (ser_last !== (k == 9)) begin
          failures++; $error("FAIL beat_last observed=%0h k=%0d", ser_last, k);
        end
        if (ser_ready) k++;
      end
      step();
      budget++;
      rdy = ~rdy;
    end
    checks++;
    if (k !== 10) begin
      failures++; $error("FAIL beat_count observed=%0d", k);
    end
    ser_ready = 1'b0;
  endtask

  task automatic chk_zero();
    checks++;
    if (ser_valid !== 1'b0) begin failures++; $error("FAIL zero_valid"); end
    checks++;
    if (ser_data !== 50'h0) begin failures++; $error("FAIL zero_data"); end
    checks++;
    if (ser_addr !== 13'h0) begin failures++; $error("FAIL zero_addr"); end
    checks++;
    if (ser_last !== 1'b0) begin failures++; $error("FAIL zero_last"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $error("FAIL zero_busy"); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $error("FAIL zero_done"); end
    checks++;
    if (line_cnt !== 10'h0) begin failures++; $error("FAIL zero_cnt"); end
    checks++;
    if (line_err !== 1'b0) begin failures++; $error("FAIL zero_err"); end
    checks++;
    if (fifo_rd !== 1'b0) begin failures++; $error("FAIL zero_rd"); end
  endtask

  initial begin
    aresetn = 1'b0;
    start = 1'b0;
    lines = '0;
    ser_ready = 1'b0;
    upd_fifo();
    repeat (3) step();
    chk_zero();
    aresetn = 1'b1;
    step();

    // T1
    fifo_q.push_back(make_word(3, 1));
    upd_fifo();
    pops_base = pops;
    lines = 10'd1;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $error("FAIL t1_busy"); end
    checks++;
    if (fifo_rd !== 1'b1) begin failures++; $error("FAIL t1_rd"); end
    run_line(3, 1, 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $error("FAIL t1_done"); end
    checks++;
    if (line_cnt !== 10'd1) begin failures++; $error("FAIL t1_cnt observed=%0d", line_cnt); end
    step();
    checks++;
    if (frame_done !== 1'b0) begin failures++; $error("FAIL t1_done_once"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $error("FAIL t1_idle"); end
    checks++;
    if (pops - pops_base !== 1) begin failures++; $error("FAIL t1_pops observed=%0d", pops - pops_base); end

    // T2
    fifo_q.push_back(make_word(7, 2));
    upd_fifo();
    pops_base = pops;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    run_line(7, 2, 1'b1);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $error("FAIL t2_done"); end
    checks++;
    if (pops - pops_base !== 1) begin failures++; $error("FAIL t2_pops observed=%0d", pops - pops_base); end
    step();

    // T3
    fifo_q.push_back(make_word(20, 3));
    upd_fifo();
    pops_base = pops;
    lines = 10'd3;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    run_line(20, 3, 1'b0);
    checks++;
    if (line_cnt !== 10'd1) begin failures++; $error("FAIL t3_cnt1 observed=%0d", line_cnt); end
    repeat (5) step();
    checks++;
    if (busy !== 1'b1) begin failures++; $error("FAIL t3_stall_busy"); end
    checks++;
    if (ser_valid !== 1'b0) begin failures++; $error("FAIL t3_stall_valid"); end
    checks++;
    if (fifo_rd !== 1'b0) begin failures++; $error("FAIL t3_stall_rd"); end
    fifo_q.push_back(make_word(21, 4));
    upd_fifo();
    run_line(21, 4, 1'b0);
    checks++;
    if (line_cnt !== 10'd2) begin failures++; $error("FAIL t3_cnt2 observed=%0d", line_cnt); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $error("FAIL t3_not_done"); end
    repeat (5) step();
    fifo_q.push_back(make_word(22, 5));
    upd_fifo();
    run_line(22, 5, 1'b0);
    checks++;
    if (line_cnt !== 10'd3) begin failures++; $error("FAIL t3_cnt3 observed=%0d", line_cnt); end
    checks++;
    if (frame_done !== 1'b1) begin failures++; $error("FAIL t3_done"); end
    checks++;
    if (pops - pops_base !== 3) begin failures++; $error("FAIL t3_pops observed=%0d", pops - pops_base); end
    step();

    // T4
    fifo_q.push_back(make_word(511, 6));
    fifo_q.push_back(make_word(40, 7));
    upd_fifo();
    pops_base = pops;
    lines = 10'd1;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin failures++; $error("FAIL t4_rd_bad"); end
    checks++;
    if (line_err !== 1'b0) begin failures++; $error("FAIL t4_err_pre"); end
    step();
    checks++;
    if (line_err !== 1'b1) begin failures++; $error("FAIL t4_err"); end
    checks++;
    if (ser_valid !== 1'b0) begin failures++; $error("FAIL t4_no_beat"); end
    run_line(40, 7, 1'b0);
    checks++;
    if (line_cnt !== 10'd1) begin failures++; $error("FAIL t4_cnt observed=%0d", line_cnt); end
    checks++;
    if (line_err !== 1'b1) begin failures++; $error("FAIL t4_err_sticky"); end
    checks++;
    if (pops - pops_base !== 2) begin failures++; $error("FAIL t4_pops observed=%0d", pops - pops_base); end
    step();

    // T5
    fifo_q.push_back(make_word(9, 8));
    fifo_q.push_back(make_word(10, 9));
    upd_fifo();
    pops_base = pops;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    checks++;
    if (line_err !== 1'b0) begin failures++; $error("FAIL t5_err_cleared"); end
    ser_ready = 1'b1;
    #1;
    step();
    repeat (4) begin
      #1;
      step();
    end
    checks++;
    if (ser_addr !== 13'd94) begin failures++; $error("FAIL t5_beat4_addr observed=%0d", ser_addr); end
    checks++;
    if (ser_data !== rev50(slice_val(8, 5))) begin failures++; $error("FAIL t5_beat4_data observed=%0h", ser_data); end
    aresetn = 1'b0;
    #1;
    chk_zero();
    ser_ready = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    repeat (3) step();
    checks++;
    if (fifo_rd !== 1'b0) begin failures++; $error("FAIL t5_no_rd"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $error("FAIL t5_idle"); end
    checks++;
    if (pops - pops_base !== 1) begin failures++; $error("FAIL t5_pops observed=%0d", pops - pops_base); end
    fifo_q.delete();
    upd_fifo();

    // T6
    fifo_q.push_back(make_word(50, 10));
    upd_fifo();
    pops_base = pops;
    lines = 10'd0;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin failures++; $error("FAIL t6_done"); end
    checks++;
    if (busy !== 1'b1) begin failures++; $error("FAIL t6_busy"); end
    step();
    checks++;
    if (frame_done !== 1'b0) begin failures++; $error("FAIL t6_done_once"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $error("FAIL t6_idle"); end
    checks++;
    if (pops - pops_base !== 0) begin failures++; $error("FAIL t6_no_pops observed=%0d", pops - pops_base); end
    lines = 10'd1;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    ser_ready = 1'b0;
    #1;
    step();
    lines = 10'd3;
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    checks++;
    if (ser_valid !== 1'b1) begin failures++; $error("FAIL t6_shift_valid"); end
    run_line(50, 10, 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $error("FAIL t6_done2"); end
    checks++;
    if (line_cnt !== 10'd1) begin failures++; $error("FAIL t6_cnt observed=%0d", line_cnt); end
    checks++;
    if (pops - pops_base !== 1) begin failures++; $error("FAIL t6_pops observed=%0d", pops - pops_base); end
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $error("FAIL t6_idle2"); end

    checks++;
    if (rd_viol !== 0) begin failures++; $error("FAIL rd_when_empty observed=%0d", rd_viol); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
